// File: rtl/instr_fetch.sv
// instr_fetch: sequential instruction fetch unit with a small {pc, instr} queue and redirect flush
module instr_fetch #(
  parameter int N = 32,
  parameter int A = 32,
  parameter logic [A-1:0] RESET_PC = '0,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fetch_en,
  input  logic         redirect_valid,
  input  logic [A-1:0] redirect_pc,
  output logic [A-1:0] imem_addr,
  input  logic [N-1:0] imem_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_instr,
  output logic [A-1:0] out_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [A-1:0] pc;
  logic [CW-1:0] count;
  logic [PW-1:0] head, tail;
  logic [A-1:0] pc_q [DEPTH];
  logic [N-1:0] instr_q [DEPTH];
  logic push, pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign imem_addr = pc;
  assign out_valid = (count != '0) && !redirect_valid;
  assign pop = out_valid && out_ready;
  assign push = fetch_en && !redirect_valid && ((count < CW'(DEPTH)) || pop);
  assign out_instr = instr_q[head];
  assign out_pc = pc_q[head];
  // pc, queue pointers and occupancy; a redirect flushes and retargets ahead of everything else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_PC;
      count <= '0;
      head <= '0;
      tail <= '0;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[A-1:2], 2'b00};
      count <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      if (push) begin
        pc <= pc + A'(4);
        tail <= nxt(tail);
      end
      if (pop) head <= nxt(head);
      count <= count + CW'(push) - CW'(pop);
    end
  // queue storage; contents are only meaningful below the occupancy count, so no reset
  always_ff @(posedge clk)
    if (push) begin
      pc_q[tail] <= pc;
      instr_q[tail] <= imem_data;
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized and directed scoreboard bench for instr_fetch
module tb_instr_fetch;
  localparam int DEPTH = 2;
  localparam logic [31:0] RPC = 32'h0;
  logic clk = 0, rst_n = 0, fetch_en = 0, redirect_valid = 0, out_ready = 0, out_valid;
  logic [31:0] redirect_pc = 0, imem_addr, imem_data, out_instr, out_pc;
  int checks = 0, fails = 0;
  typedef struct {logic [31:0] pc; logic [31:0] ins;} ent_t;
  ent_t mq[$];
  logic [31:0] mpc = RPC;
  logic [31:0] delivered[$];
  logic [31:0] held;
  bit ev;
  instr_fetch #(.N(32), .A(32), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA5A50000;
  endfunction
  assign imem_data = word(imem_addr);
  function void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction
  function void chk_del(input string nm, input int i, input logic [31:0] e);
    if (i < delivered.size()) chk(nm, 64'(delivered[i]), 64'(e));
    else chk({nm, " count"}, 64'(delivered.size()), 64'(i + 1));
  endfunction
  // reference model: queue of fetched {pc, word} entries, updated at every edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mpc = RPC;
    end else if (redirect_valid) begin
      mq.delete();
      mpc = redirect_pc & ~32'h3;
    end else begin
      bit p, q;
      p = mq.size() != 0 && out_ready;
      q = fetch_en && (mq.size() < DEPTH || p);
      if (p) void'(mq.pop_front());
      if (q) begin
        mq.push_back('{mpc, word(mpc)});
        mpc = mpc + 32'd4;
      end
    end
  end
  // monitor: compare the DUT head against the model every cycle, away from the edge
  always @(negedge clk) begin
    ev = mq.size() != 0 && !redirect_valid && rst_n;
    chk("imem_addr", 64'(imem_addr), 64'(mpc));
    chk("out_valid", 64'(out_valid), 64'(ev));
    if (ev && out_valid) begin
      chk("out_pc", 64'(out_pc), 64'(mq[0].pc));
      chk("out_instr", 64'(out_instr), 64'(mq[0].ins));
    end
    if (out_valid && out_ready) delivered.push_back(out_pc);
  end
  task automatic cyc(input logic en, input logic rv, input logic [31:0] rp, input logic rdy, input int n = 1);
    fetch_en = en;
    redirect_valid = rv;
    redirect_pc = rp;
    out_ready = rdy;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    #12;
    chk("reset out_valid", 64'(out_valid), 64'(0));
    chk("reset imem_addr", 64'(imem_addr), 64'(RPC));
    rst_n = 1;
    cyc(1, 0, 0, 1, 5);
    chk_del("stream0", 0, 0);
    chk_del("stream1", 1, 4);
    chk_del("stream2", 2, 8);
    chk_del("stream3", 3, 12);
    cyc(1, 1, 0, 1);
    cyc(1, 0, 0, 0, 5);
    chk("bp pc", 64'(imem_addr), 64'(8));
    chk("bp head", 64'(out_pc), 64'(0));
    delivered.delete();
    cyc(1, 0, 0, 1, 3);
    chk_del("bp0", 0, 0);
    chk_del("bp1", 1, 4);
    chk_del("bp2", 2, 8);
    cyc(1, 0, 0, 0, 2);
    delivered.delete();
    fetch_en = 1;
    redirect_valid = 1;
    redirect_pc = 32'h103;
    out_ready = 1;
    #2;
    chk("redirect out_valid", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 1, 3);
    chk_del("redir0", 0, 32'h100);
    chk_del("redir1", 1, 32'h104);
    delivered.delete();
    cyc(1, 1, 32'hFFFFFFF8, 1);
    cyc(1, 0, 0, 1, 4);
    chk_del("wrap0", 0, 32'hFFFFFFF8);
    chk_del("wrap1", 1, 32'hFFFFFFFC);
    chk_del("wrap2", 2, 32'h0);
    cyc(1, 0, 0, 0, 3);
    #2;
    rst_n = 0;
    #1;
    chk("midreset out_valid", 64'(out_valid), 64'(0));
    chk("midreset imem_addr", 64'(imem_addr), 64'(RPC));
    @(posedge clk);
    #2;
    rst_n = 1;
    delivered.delete();
    cyc(1, 0, 0, 1, 3);
    chk_del("restart0", 0, RPC);
    chk_del("restart1", 1, RPC + 4);
    held = mpc;
    cyc(0, 0, 0, 1, 3);
    chk("gate out_valid", 64'(out_valid), 64'(0));
    chk("gate pc held", 64'(imem_addr), 64'(held));
    delivered.delete();
    cyc(1, 0, 0, 1, 3);
    chk_del("resume0", 0, held);
    chk_del("resume1", 1, held + 4);
    repeat (400)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 3) != 0);
    cyc(0, 0, 0, 0, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter N, default 32, instruction data width in bits.
REQ-002 The block SHALL have parameter A, default 32, instruction address width in bits.
REQ-003 The block SHALL have parameter RESET_PC, default 0, the first fetch address after reset.
REQ-004 The block SHALL have parameter DEPTH, default 2, the fetch queue depth in entries (legal values 2..8).
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-007 The block SHALL have port fetch_en, input, 1, which permits new fetches when high.
REQ-008 The block SHALL have port redirect_valid, input, 1, a control-flow change request.
REQ-009 The block SHALL have port redirect_pc, input, A, the redirect target byte address.
REQ-010 The block SHALL have port imem_addr, output, A, the byte address presented to instruction memory.
REQ-011 The block SHALL have port imem_data, input, N, the instruction word returned combinationally for imem_addr in the same cycle.
REQ-012 The block SHALL have port out_valid, output, 1, meaning the queue head holds a valid instruction.
REQ-013 The block SHALL have port out_ready, input, 1, meaning the consumer accepts the queue head.
REQ-014 The block SHALL have port out_instr, output, N, the instruction word at the queue head.
REQ-015 The block SHALL have port out_pc, output, A, the byte address of out_instr.

Function
REQ-016 The block SHALL hold a registered pc and drive imem_addr = pc at all times, with no combinational path from inputs to imem_addr.
REQ-017 The block SHALL keep a FIFO of DEPTH entries, each holding {pc, instr}, plus an occupancy count from 0 to DEPTH.
REQ-018 pop SHALL be out_valid && out_ready; a transfer occurs only on a clock edge where pop is high.
REQ-019 push SHALL be fetch_en && !redirect_valid && (count < DEPTH || pop); on push, entry {pc, imem_data} is written at the tail and pc <= pc + 4.
REQ-020 pc increment SHALL be modulo 2^A, so 0xFFFF_FFFC + 4 wraps to 0x0000_0000 with no flag.
REQ-021 A simultaneous push and pop SHALL leave count unchanged and keep order; the queue full with pop high SHALL still accept a push.
REQ-022 out_valid SHALL be (count != 0) && !redirect_valid; out_instr/out_pc SHALL show the head entry and hold stable while out_valid && !out_ready.
REQ-023 When redirect_valid is high at an edge, the block SHALL empty the queue (count <= 0), set pc <= {redirect_pc[A-1:2], 2'b00}, and perform no push and no pop.
REQ-024 redirect_valid SHALL have priority over push, pop and fetch_en; back-to-back redirects SHALL each retarget pc, with the last one taking effect.
REQ-025 The first instruction from a redirect target SHALL appear with out_valid high one cycle after the redirect edge, provided fetch_en is high.
REQ-026 With fetch_en low, the block SHALL make no push and hold pc, while pops continue to drain the queue.
REQ-027 Sustained throughput SHALL be one instruction per cycle when fetch_en and out_ready are held high.
REQ-028 out_instr and out_pc SHALL be don't-care while out_valid is low.

Reset
REQ-029 While rst_n is low, the block SHALL immediately set pc = RESET_PC, imem_addr = RESET_PC, count = 0 and out_valid = 0, regardless of clk.
REQ-030 Reset asserted mid-stream SHALL discard all queued entries; no instruction fetched before the reset SHALL appear after it.
REQ-031 At the first rising edge after rst_n goes high with fetch_en high, the block SHALL push RESET_PC; out_valid SHALL be 1 in the following cycle with out_pc = RESET_PC.

Verification
REQ-032 Reset then stream: memory returns word = addr ^ 0xA5A5_0000, with fetch_en = 1 and out_ready = 1 -> out_pc sequence 0, 4, 8, 12 on consecutive cycles with matching words and no gaps.
REQ-033 Backpressure: out_ready = 0 for 5 cycles -> count saturates at 2, pc stops at 8, head stays at pc 0; release out_ready -> pcs 0, 4, 8 are delivered in order with none lost or duplicated.
REQ-034 Redirect: with 2 entries queued, pulse redirect_valid with redirect_pc = 0x0000_0103 -> out_valid is 0 in that cycle, queue is flushed, next delivered out_pc = 0x100, then 0x104.
REQ-035 Wrap-around: redirect to 0xFFFF_FFF8 -> delivered out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-036 Mid-operation reset: assert rst_n low asynchronously between edges with the queue full -> out_valid drops to 0 and imem_addr = RESET_PC at once; after release the stream restarts at RESET_PC.
REQ-037 fetch_en gating: drop fetch_en for 3 cycles with out_ready = 1 -> queue drains to empty, out_valid = 0, pc is held; re-enable fetch_en -> the stream resumes at the held pc.
